// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply / restoring divide.
// Optional MULDIV_EARLY_OUT_EN finishes trivial operands after a single BUSY cycle.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_hi, r_lo, r_opnd, r_result, r_early_res;
  logic                r_neg, r_early;

  // accept-side decode
  logic                w_is_div, w_a_sgn, w_b_sgn, w_neg, w_accept, w_last;
  logic [XLEN-1:0]     w_ma, w_mb;
  logic                w_early;
  logic [XLEN-1:0]     w_early_res;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_is_div = in_op[2];
  assign w_a_sgn  = in_a[XLEN-1] & (w_is_div ? ~in_op[0] : (in_op == 3'b001 || in_op == 3'b010));
  assign w_b_sgn  = in_b[XLEN-1] & (w_is_div ? ~in_op[0] : (in_op == 3'b001));
  assign w_ma     = w_a_sgn ? -in_a : in_a;
  assign w_mb     = w_b_sgn ? -in_b : in_b;

  // Quotient sign is suppressed for b==0 so signed DIV by zero yields all ones.
  always_comb begin
    w_neg = w_a_sgn ^ w_b_sgn;
    if (w_is_div && in_op[1])  w_neg = w_a_sgn;
    else if (w_is_div)         w_neg = (w_a_sgn ^ w_b_sgn) & (|in_b);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic w_zero_a, w_zero_b, w_ovf;
  assign w_zero_a = (in_a == '0);
  assign w_zero_b = (in_b == '0);
  assign w_ovf    = w_is_div && !in_op[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
  assign w_early  = w_zero_a | w_zero_b | w_ovf;
  always_comb begin
    w_early_res = '0;
    if (w_is_div) begin
      if (w_zero_b)   w_early_res = in_op[1] ? in_a : '1;
      else if (w_ovf) w_early_res = in_op[1] ? '0 : in_a;
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  // one radix-2 step
  logic [XLEN:0]       w_sum, w_shift, w_diff;
  logic [XLEN-1:0]     w_hi_n, w_lo_n, w_final;
  logic [2*XLEN-1:0]   w_prod_s;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};

  always_comb begin
    w_hi_n = w_sum[XLEN:1];
    w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_op[2]) begin
      if (!w_diff[XLEN]) begin
        w_hi_n = w_diff[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_n = w_shift[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign w_prod_s = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};

  always_comb begin
    w_final = w_prod_s[2*XLEN-1:XLEN];
    case (r_op)
      3'b000:         w_final = w_prod_s[XLEN-1:0];
      3'b100, 3'b101: w_final = r_neg ? -w_lo_n : w_lo_n;
      3'b110, 3'b111: w_final = r_neg ? -w_hi_n : w_hi_n;
      default:        w_final = w_prod_s[2*XLEN-1:XLEN];
    endcase
  end

  assign w_last = (r_cnt == CW'(XLEN-1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = BUSY;
      BUSY:    if (r_early || w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_neg       <= 1'b0;
      r_early     <= 1'b0;
      r_early_res <= '0;
      r_result    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt       <= '0;
        r_op        <= in_op;
        r_hi        <= '0;
        r_lo        <= w_is_div ? w_ma : w_mb;
        r_opnd      <= w_is_div ? w_mb : w_ma;
        r_neg       <= w_neg;
        r_early     <= w_early;
        r_early_res <= w_early_res;
        r_result    <= '0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        r_hi  <= w_hi_n;
        r_lo  <= w_lo_n;
        if (r_early)     r_result <= r_early_res;
        else if (w_last) r_result <= w_final;
      end else if (r_state == DONE && out_ready) begin
        r_result <= '0;
      end
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_result = r_result;

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values even, >= 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port in_op  input  3  operation, RISC-V funct3 coding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port in_a  input  XLEN  operand 1 (multiplicand/dividend).
REQ-008 SHALL have port in_b  input  XLEN  operand 2 (multiplier/divisor).
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_result  output  XLEN  result.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL accept on edge with in_valid & in_ready: latch in_op/in_a/in_b, clear iteration counter, IDLE->BUSY; later input changes ignored.
REQ-014 SHALL perform one radix-2 iteration per BUSY edge (shift-add multiply, restoring divide on operand magnitudes); after XLEN iterations, BUSY->DONE.
REQ-015 SHALL give latency XLEN+1 cycles from accept cycle to first out_valid cycle (33 for XLEN=32).
REQ-016 SHALL hold out_result and out_valid stable in DONE until out_ready=1; DONE & out_ready edge -> IDLE; no new accept in that same cycle.
REQ-017 SHALL ignore in_valid while BUSY or DONE (no queuing).
REQ-018 SHALL return low XLEN bits of product for MUL; high XLEN bits of 2*XLEN product for MULH (signed x signed), MULHSU (signed a x unsigned b), MULHU (unsigned x unsigned).
REQ-019 SHALL return quotient truncated toward zero for DIV/DIVU; remainder with sign of dividend for REM/REMU.
REQ-020 SHALL on divisor zero return all ones (DIV, DIVU) and dividend unchanged (REM, REMU).
REQ-021 SHALL on DIV/REM with a = most-negative, b = -1 return a (DIV) and 0 (REM); no other side effect.
REQ-022 SHALL hold out_result 0 whenever state is IDLE or BUSY.

Reset
REQ-023 SHALL on rst=1 at any edge force state IDLE, counter 0, out_valid 0, out_result 0, in_ready 1 on following cycle; in-flight operation abandoned, no result produced.
REQ-024 SHALL give rst priority over accept and over out_ready handshake in same cycle.

Configuration
REQ-025 SHALL use macro MULDIV_EARLY_OUT_EN.
REQ-026 SHALL with MULDIV_EARLY_OUT_EN defined: divide-by-zero, signed overflow (REQ-021) and any operation with in_a==0 or in_b==0 go IDLE->BUSY->DONE after one BUSY edge (latency 2), results per REQ-018..021.
REQ-027 SHALL with MULDIV_EARLY_OUT_EN undefined: every operation takes full XLEN+1 latency; results identical to defined case.

Verification (XLEN=32)
REQ-028 SHALL cover MUL a=7, b=0xFFFFFFFD -> out_result 0xFFFFFFEB, out_valid first high 33 cycles after accept; MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 SHALL cover DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, REM -> 0; latency 2 with MULDIV_EARLY_OUT_EN, 33 without.
REQ-031 SHALL cover backpressure: out_ready low 10 cycles after DONE -> out_result/out_valid stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-032 SHALL cover reset during BUSY at iteration 10 -> next cycle in_ready 1, out_valid 0, out_result 0; following MUL 3*4 -> 12 with normal latency.
